// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream funnel with packet locking and a single output register stage.
// Arbitration is round-robin (mode = 0) or fixed lowest-index priority (mode = 1).
module stream_mux_arb #(
  parameter int unsigned data_width = 8,
  parameter int unsigned num_ch     = 4,
  parameter int unsigned sel_width  = $clog2(num_ch)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic [num_ch*data_width-1:0] in_data,
  input  logic [num_ch-1:0]            in_valid,
  input  logic [num_ch-1:0]            in_last,
  output logic [num_ch-1:0]            in_ready,
  output logic [data_width-1:0]        out_data,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [sel_width-1:0]         out_sel,
  input  logic                         out_ready
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [sel_width-1:0]  lock_ch_q, lock_ch_d;
  logic [sel_width-1:0]  rr_ptr_q, rr_ptr_d;
  logic [data_width-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [sel_width-1:0]  out_sel_q, out_sel_d;

  logic                  load_en;
  logic                  grant_valid;
  logic [sel_width-1:0]  grant_idx;
  logic [sel_width-1:0]  cur_ch;
  logic                  xfer;
  logic [data_width-1:0] cur_data;
  logic                  cur_last;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin runs two passes: channels at/after rr_ptr first, then the wrapped ones.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode) begin
      for (int i = 0; i < int'(num_ch); i++) begin
        if (!grant_valid && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = sel_width'(i);
        end
      end
    end else begin
      for (int i = 0; i < int'(num_ch); i++) begin
        if (!grant_valid && in_valid[i] && (sel_width'(i) >= rr_ptr_q)) begin
          grant_valid = 1'b1;
          grant_idx   = sel_width'(i);
        end
      end
      for (int i = 0; i < int'(num_ch); i++) begin
        if (!grant_valid && in_valid[i] && (sel_width'(i) < rr_ptr_q)) begin
          grant_valid = 1'b1;
          grant_idx   = sel_width'(i);
        end
      end
    end
  end

  assign cur_ch = (state_q == StLocked) ? lock_ch_q : grant_idx;

  always_comb begin
    in_ready = '0;
    if (!rst) begin
      if (state_q == StLocked) begin
        in_ready[lock_ch_q] = load_en;
      end else if (load_en && grant_valid) begin
        in_ready[grant_idx] = 1'b1;
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  always_comb begin
    cur_data = '0;
    cur_last = 1'b0;
    for (int i = 0; i < int'(num_ch); i++) begin
      if (cur_ch == sel_width'(i)) begin
        cur_data = in_data[i*data_width +: data_width];
        cur_last = in_last[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = cur_data;
        out_last_d = cur_last;
        out_sel_d  = cur_ch;
      end
    end
    if (xfer) begin
      if (state_q == StIdle && !cur_last) begin
        state_d   = StLocked;
        lock_ch_d = cur_ch;
      end else if (state_q == StLocked && cur_last) begin
        state_d = StIdle;
      end
      if (cur_last) begin
        rr_ptr_d = (cur_ch == sel_width'(num_ch - 1)) ? '0 : cur_ch + sel_width'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench: a 4-channel instance for most scenarios and a 3-channel one for wrap/reset.
module tb_stream_mux_arb;

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic        a_rst, a_mode, a_out_ready;
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_last, a_in_ready;
  logic [7:0]  a_out_data;
  logic        a_out_valid, a_out_last;
  logic [1:0]  a_out_sel;

  logic        b_rst, b_mode, b_out_ready;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_last, b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_last;
  logic [1:0]  b_out_sel;

  always #5 clk = ~clk;

  stream_mux_arb #(.data_width(8), .num_ch(4)) u_dut4 (
    .clk       (clk),
    .rst       (a_rst),
    .mode      (a_mode),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_last   (a_in_last),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_last  (a_out_last),
    .out_sel   (a_out_sel),
    .out_ready (a_out_ready)
  );

  stream_mux_arb #(.data_width(8), .num_ch(3)) u_dut3 (
    .clk       (clk),
    .rst       (b_rst),
    .mode      (b_mode),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_last   (b_in_last),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_last  (b_out_last),
    .out_sel   (b_out_sel),
    .out_ready (b_out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic a_reset();
    a_rst = 1'b1;
    step();
    step();
    a_rst = 1'b0;
  endtask

  task automatic test_reset();
    a_mode = 1'b0; a_out_ready = 1'b1;
    a_in_valid = 4'hF; a_in_last = 4'hF;
    a_in_data = 32'h13121110;
    a_rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (a_in_ready !== 4'h0) begin
        failures++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0000", c, a_in_ready);
      end
      step();
      checks++;
      if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_last !== 1'b0 ||
          a_out_sel !== 2'd0) begin
        failures++;
        $display("FAIL reset_out cyc=%0d got v=%b d=%h l=%b s=%0d exp 0/00/0/0",
                 c, a_out_valid, a_out_data, a_out_last, a_out_sel);
      end
    end
    a_rst = 1'b0;
    settle();
    checks++;
    if (a_in_ready !== 4'b0001) begin
      failures++; $display("FAIL reset_first_grant got=%b exp=0001", a_in_ready);
    end
    step();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sel !== 2'd0 || a_out_data !== 8'h10) begin
      failures++;
      $display("FAIL reset_first_beat got v=%b s=%0d d=%h exp 1/0/10",
               a_out_valid, a_out_sel, a_out_data);
    end
  endtask

  task automatic test_round_robin();
    a_mode = 1'b0; a_out_ready = 1'b1;
    a_in_valid = 4'hF; a_in_last = 4'hF;
    a_in_data = 32'h13121110;
    a_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_sel !== 2'(k % 4) || a_out_data !== 8'(8'h10 + k % 4)
          || a_out_last !== 1'b1) begin
        failures++;
        $display("FAIL rr_seq k=%0d got v=%b s=%0d d=%h exp 1/%0d/%h", k, a_out_valid,
                 a_out_sel, a_out_data, k % 4, 8'h10 + k % 4);
      end
    end
  endtask

  task automatic test_packet_lock();
    a_mode = 1'b0; a_out_ready = 1'b1;
    a_in_valid = 4'h0; a_in_last = 4'h0; a_in_data = '0;
    a_reset();
    a_in_valid = 4'b0110; a_in_last = 4'b0100;
    a_in_data = 32'h00B2A100;
    for (int b = 0; b < 3; b++) begin
      settle();
      checks++;
      if (a_in_ready !== 4'b0010) begin
        failures++; $display("FAIL lock_ready beat=%0d got=%b exp=0010", b, a_in_ready);
      end
      step();
      checks++;
      if (a_out_sel !== 2'd1 || a_out_data !== 8'(8'hA1 + b) || a_out_last !== (b == 2)) begin
        failures++;
        $display("FAIL lock_beat b=%0d got s=%0d d=%h l=%b exp 1/%h/%b", b, a_out_sel,
                 a_out_data, a_out_last, 8'hA1 + b, b == 2);
      end
      a_in_data[15:8] = 8'(8'hA2 + b);
      if (b == 1) a_in_last[1] = 1'b1;
    end
    a_in_valid[1] = 1'b0;
    settle();
    checks++;
    if (a_in_ready !== 4'b0100) begin
      failures++; $display("FAIL lock_release_ready got=%b exp=0100", a_in_ready);
    end
    step();
    checks++;
    if (a_out_sel !== 2'd2 || a_out_data !== 8'hB2 || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL lock_next got s=%0d d=%h v=%b exp 2/b2/1", a_out_sel, a_out_data, a_out_valid);
    end
  endtask

  task automatic test_fixed_priority();
    a_mode = 1'b1; a_out_ready = 1'b1;
    a_in_valid = 4'b1001; a_in_last = 4'b1001;
    a_in_data = 32'h13000010;
    a_reset();
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if (a_in_ready !== 4'b0001) begin
        failures++; $display("FAIL fixed_ready k=%0d got=%b exp=0001", k, a_in_ready);
      end
      step();
      checks++;
      if (a_out_sel !== 2'd0 || a_out_data !== 8'h10) begin
        failures++;
        $display("FAIL fixed_ch0 k=%0d got s=%0d d=%h exp 0/10", k, a_out_sel, a_out_data);
      end
    end
    a_in_valid[0] = 1'b0;
    step();
    checks++;
    if (a_out_sel !== 2'd3 || a_out_data !== 8'h13 || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL fixed_ch3 got s=%0d d=%h v=%b exp 3/13/1", a_out_sel, a_out_data, a_out_valid);
    end
  endtask

  task automatic test_backpressure();
    a_mode = 1'b0; a_out_ready = 1'b1;
    a_in_valid = 4'b0001; a_in_last = 4'b0001;
    a_in_data = 32'h00000055;
    a_reset();
    step();
    a_out_ready = 1'b0;
    a_in_data[7:0] = 8'h66;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (a_in_ready !== 4'h0) begin
        failures++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, a_in_ready);
      end
      step();
      checks++;
      if (a_out_data !== 8'h55 || a_out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold c=%0d got d=%h v=%b exp 55/1", c, a_out_data, a_out_valid);
      end
    end
    a_out_ready = 1'b1;
    settle();
    checks++;
    if (a_in_ready !== 4'b0001) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=0001", a_in_ready);
    end
    step();
    checks++;
    if (a_out_data !== 8'h66 || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got d=%h v=%b exp 66/1", a_out_data, a_out_valid);
    end
    a_in_valid = 4'h0;
    step();
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 8'h66 || a_out_sel !== 2'd0 ||
        a_out_last !== 1'b1) begin
      failures++;
      $display("FAIL idle_hold got v=%b d=%h s=%0d l=%b exp 0/66/0/1", a_out_valid, a_out_data,
               a_out_sel, a_out_last);
    end
  endtask

  task automatic test_reset_mid_packet_np2();
    b_mode = 1'b0; b_out_ready = 1'b1;
    b_in_valid = 3'b100; b_in_last = 3'b000;
    b_in_data = 24'h210000;
    b_rst = 1'b1;
    step();
    step();
    b_rst = 1'b0;
    step();
    checks++;
    if (b_out_sel !== 2'd2 || b_out_data !== 8'h21 || b_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL np2_beat1 got s=%0d d=%h v=%b exp 2/21/1", b_out_sel, b_out_data, b_out_valid);
    end
    b_in_data = 24'h223130;
    b_in_valid = 3'b111; b_in_last = 3'b011;
    b_rst = 1'b1;
    settle();
    checks++;
    if (b_in_ready !== 3'b000) begin
      failures++; $display("FAIL np2_rst_ready got=%b exp=000", b_in_ready);
    end
    step();
    checks++;
    if (b_out_valid !== 1'b0) begin
      failures++; $display("FAIL np2_rst_valid got=%b exp=0", b_out_valid);
    end
    b_rst = 1'b0;
    b_in_last = 3'b111;
    settle();
    checks++;
    if (b_in_ready !== 3'b001) begin
      failures++; $display("FAIL np2_regrant got=%b exp=001", b_in_ready);
    end
    for (int k = 0; k < 7; k++) begin
      step();
      checks++;
      if (b_out_sel !== 2'(k % 3) || b_out_valid !== 1'b1) begin
        failures++;
        $display("FAIL np2_wrap k=%0d got s=%0d v=%b exp %0d/1", k, b_out_sel, b_out_valid, k % 3);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    b_rst = 1'b1; b_mode = 1'b0; b_out_ready = 1'b1;
    b_in_valid = '0; b_in_last = '0; b_in_data = '0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_fixed_priority();
    test_backpressure();
    test_reset_mid_packet_np2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
